// File: rtl/onecold6_decoder_if.sv
// -----------------------------------------------------------------------------
// onecold6_decoder_if
//   Handshake bundle for the one-cold decoder: an input stream of 6-bit code
//   words and an output stream of decoded {idx, err} results.
//
//   in_valid  : source presents in_code
//   in_ready  : decoder can accept a word this cycle
//   in_code   : 6-bit code word, bit i = y[i] of the generator
//   out_valid : decoder FIFO head holds a result
//   out_ready : consumer takes the head this cycle
//   out_idx   : decoded index of the head entry
//   out_err   : head entry came from an illegal word
//
//   master : the side that sources code words and consumes results
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface onecold6_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_err;

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_err
  );
endinterface

// File: rtl/onecold6_decoder.sv
// -----------------------------------------------------------------------------
// onecold6_decoder
//   Registered inverse of the 3-bit to 6-bit one-cold code generator.
//   Accepted code words are decoded to a 3-bit index and pushed into a
//   2-entry FIFO; words outside the code set are stored as idx=0, err=1 and
//   counted in a saturating error counter.
//
//   Parameters
//     EXT_CODES : 1 -> 101011 decodes to 6 and 010111 to 7; 0 -> both illegal
//     ERR_W     : width of err_cnt
//
//   Ports
//     clk     : clock, all state on rising edge
//     rst     : asynchronous, active-high reset
//     bus     : code-word input stream and result output stream (slave side)
//     err_clr : synchronous clear of err_cnt
//     err_cnt : saturating count of accepted illegal words
//
//   Outputs carry no combinational path from in_valid/in_code: in_ready is a
//   function of the entry count, out_* are a function of FIFO registers only.
// -----------------------------------------------------------------------------
module onecold6_decoder #(
  parameter bit EXT_CODES = 1'b1,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  onecold6_decoder_if.slave    bus,
  input  logic                 err_clr,
  output logic [ERR_W-1:0]     err_cnt
);

  typedef struct packed {
    logic [2:0] idx;
    logic       err;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{idx: 3'd0, err: 1'b0};
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // ---------------------------------------------------------------------------
  // Decode of the presented word (only stored when accepted)
  // ---------------------------------------------------------------------------
  entry_t dec;

  always_comb begin
    // NOTE: assign a default before the case so every path drives dec;
    // otherwise synthesis infers a latch for the unlisted code words.
    dec = '{idx: 3'd0, err: 1'b1};
    case (bus.in_code)
      6'b111110: dec = '{idx: 3'd0, err: 1'b0};
      6'b111101: dec = '{idx: 3'd1, err: 1'b0};
      6'b111011: dec = '{idx: 3'd2, err: 1'b0};
      6'b110111: dec = '{idx: 3'd3, err: 1'b0};
      6'b101111: dec = '{idx: 3'd4, err: 1'b0};
      6'b011111: dec = '{idx: 3'd5, err: 1'b0};
      // Extended words sit outside the one-cold set and are optional.
      6'b101011: if (EXT_CODES) dec = '{idx: 3'd6, err: 1'b0};
      6'b010111: if (EXT_CODES) dec = '{idx: 3'd7, err: 1'b0};
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------------
  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic push;
  logic pop;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // A popped slot keeps its old contents, so the head is gated to zero when
  // the FIFO is empty.
  assign bus.out_idx = bus.out_valid ? mem[rd_ptr].idx : 3'd0;
  assign bus.out_err = bus.out_valid ? mem[rd_ptr].err : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two storage slots are reset too, because a cleared FIFO is
      // part of the defined reset state; larger buffers would normally not be.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= ENTRY_EMPTY;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave the count unchanged; at count=1 the new
      // entry lands in the slot the read pointer moves to.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter, updated at accept time
  // ---------------------------------------------------------------------------
  logic count_err;

  assign count_err = push & dec.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      // A clear coinciding with an illegal accept still records that word.
      err_cnt <= count_err ? ERR_W'(1) : '0;
    end else if (count_err && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_onecold6_decoder.sv
// -----------------------------------------------------------------------------
// tb_onecold6_decoder
//   Two decoders share one stimulus stream: dut_a (EXT_CODES=1, ERR_W=8) and
//   dut_b (EXT_CODES=0, ERR_W=2). Their FIFO occupancy is identical, so a
//   single queue of accepted raw code words serves as the reference, decoded
//   per instance. A compare process checks every output of both instances on
//   each falling edge; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_onecold6_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_code = 6'd0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onecold6_decoder_if bus_a ();
  onecold6_decoder_if bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_code   = in_code;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_code   = in_code;
  assign bus_b.out_ready = out_ready;

  onecold6_decoder #(.EXT_CODES(1'b1), .ERR_W(8)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_a),
    .err_clr (err_clr),
    .err_cnt (err_cnt_a)
  );

  onecold6_decoder #(.EXT_CODES(1'b0), .ERR_W(2)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_b),
    .err_clr (err_clr),
    .err_cnt (err_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: a legal one-cold word has exactly one zero, whose
  // position is the index. Returns {err, idx[2:0]}.
  function automatic logic [3:0] ref_decode(input logic [5:0] c, input bit ext);
    if ($countones(c) == 5) begin
      for (int i = 0; i < 6; i++) begin
        if (c[i] == 1'b0) return {1'b0, 3'(i)};
      end
    end
    if (ext && c == 6'b101011) return 4'b0110;
    if (ext && c == 6'b010111) return 4'b0111;
    return 4'b1000;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: queue of accepted words plus two error counters
  // ---------------------------------------------------------------------------
  logic [5:0] mq [$];
  int m_err_a = 0;
  int m_err_b = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_err_a = 0;
        m_err_b = 0;
      end else begin
        bit acc;
        bit pop;
        bit ill_a;
        bit ill_b;
        acc   = in_valid && (mq.size() < 2);
        pop   = (mq.size() > 0) && out_ready;
        ill_a = ref_decode(in_code, 1'b1) >> 3;
        ill_b = ref_decode(in_code, 1'b0) >> 3;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in_code);
        if (err_clr) begin
          m_err_a = (acc && ill_a) ? 1 : 0;
          m_err_b = (acc && ill_b) ? 1 : 0;
        end else begin
          if (acc && ill_a && m_err_a < 255) m_err_a++;
          if (acc && ill_b && m_err_b < 3)   m_err_b++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [3:0] ea;
        logic [3:0] eb;
        bit         nonempty;
        nonempty = (mq.size() != 0);
        ea = nonempty ? ref_decode(mq[0], 1'b1) : 4'b0000;
        eb = nonempty ? ref_decode(mq[0], 1'b0) : 4'b0000;
        check("cmp_a_in_ready",  32'(bus_a.in_ready),  32'(mq.size() != 2));
        check("cmp_a_out_valid", 32'(bus_a.out_valid), 32'(nonempty));
        check("cmp_a_out_idx",   32'(bus_a.out_idx),   32'(ea[2:0]));
        check("cmp_a_out_err",   32'(bus_a.out_err),   32'(ea[3]));
        check("cmp_a_err_cnt",   32'(err_cnt_a),       32'(m_err_a));
        check("cmp_b_in_ready",  32'(bus_b.in_ready),  32'(mq.size() != 2));
        check("cmp_b_out_valid", 32'(bus_b.out_valid), 32'(nonempty));
        check("cmp_b_out_idx",   32'(bus_b.out_idx),   32'(eb[2:0]));
        check("cmp_b_out_err",   32'(bus_b.out_err),   32'(eb[3]));
        check("cmp_b_err_cnt",   32'(err_cnt_b),       32'(m_err_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations
  // ---------------------------------------------------------------------------
  logic [5:0] legal [8] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111,
                            6'b101111, 6'b011111, 6'b101011, 6'b010111};

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_idx",   32'(bus_a.out_idx),   32'd0);
    check("rst_out_err",   32'(bus_a.out_err),   32'd0);
    check("rst_err_cnt",   32'(err_cnt_a),       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stream the six one-cold words with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_code  = legal[i];
      @(negedge clk);
      check("stream_valid", 32'(bus_a.out_valid), 32'd1);
      check("stream_idx",   32'(bus_a.out_idx),   32'(i));
      check("stream_err",   32'(bus_a.out_err),   32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 32'(bus_a.out_valid), 32'd0);
    check("stream_err_cnt", 32'(err_cnt_a),       32'd0);

    // Extended words: legal on dut_a, illegal on dut_b.
    in_valid = 1'b1;
    in_code  = 6'b101011;
    @(negedge clk);
    check("ext6_a_idx", 32'(bus_a.out_idx), 32'd6);
    check("ext6_a_err", 32'(bus_a.out_err), 32'd0);
    check("ext6_b_idx", 32'(bus_b.out_idx), 32'd0);
    check("ext6_b_err", 32'(bus_b.out_err), 32'd1);
    in_code = 6'b010111;
    @(negedge clk);
    check("ext7_a_idx", 32'(bus_a.out_idx), 32'd7);
    check("ext7_b_err", 32'(bus_b.out_err), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("ext_a_err_cnt", 32'(err_cnt_a), 32'd0);
    check("ext_b_err_cnt", 32'(err_cnt_b), 32'd2);

    // Stall: three words back to back with the consumer blocked.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 6'b111101;
    @(negedge clk);
    check("stall_ready1", 32'(bus_a.in_ready), 32'd1);
    check("stall_head1",  32'(bus_a.out_idx),  32'd1);
    in_code = 6'b111011;
    @(negedge clk);
    check("stall_full",  32'(bus_a.in_ready), 32'd0);
    in_code = 6'b110111;
    repeat (3) begin
      @(negedge clk);
      check("stall_held_ready", 32'(bus_a.in_ready), 32'd0);
      check("stall_head_stable", 32'(bus_a.out_idx), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_head2",  32'(bus_a.out_idx),  32'd2);
    check("drain_ready",  32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    check("drain_head3",  32'(bus_a.out_idx),  32'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_empty",  32'(bus_a.out_valid), 32'd0);

    // Error counter saturation and clear (dut_b has a 2-bit counter).
    err_clr = 1'b1;
    @(negedge clk);
    check("clr_a", 32'(err_cnt_a), 32'd0);
    check("clr_b", 32'(err_cnt_b), 32'd0);
    err_clr  = 1'b0;
    in_valid = 1'b1;
    in_code  = 6'b111111;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("sat_a", 32'(err_cnt_a), 32'(i));
      check("sat_b", 32'(err_cnt_b), 32'((i > 3) ? 3 : i));
    end
    err_clr = 1'b1;
    @(negedge clk);
    check("clr_accept_a", 32'(err_cnt_a), 32'd1);
    check("clr_accept_b", 32'(err_cnt_b), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_alone_b", 32'(err_cnt_b), 32'd0);
    err_clr = 1'b0;
    @(negedge clk);

    // Asynchronous reset with a full FIFO and a nonzero error count.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 6'b000000;
    @(negedge clk);
    in_code = 6'b111110;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_full", 32'(bus_a.in_ready), 32'd0);
    check("pre_rst_err",  32'(err_cnt_a),      32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("async_rst_ready", 32'(bus_a.in_ready),  32'd1);
    check("async_rst_err",   32'(err_cnt_a),       32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 6'b011111;
    @(negedge clk);
    check("post_rst_idx", 32'(bus_a.out_idx), 32'd5);
    check("post_rst_err", 32'(bus_a.out_err), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    // Randomised traffic, checked by the compare process.
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 7)]
                                              : 6'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
